// File: rtl/ws281x_mport_if.sv
// Push-side bus of the multi-port WS281x transmitter: one valid/ready/data
// lane per LED port, packed side by side.
interface ws281x_mport_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]    push_valid;
  logic [32*NUM_PORTS-1:0] push_data;
  logic [NUM_PORTS-1:0]    push_ready;

  modport master (output push_valid, output push_data, input push_ready);
  modport slave  (input push_valid, input push_data, output push_ready);
endinterface

// File: rtl/ws281x_mport.sv
// Multi-port WS281x serial LED driver: per-port word FIFO feeding an
// IDLE/BIT/LATCH bit-timing FSM with a registered serial output.
module ws281x_mport #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 mclk,
  input  logic                 h_reset,
  input  logic [15:0]          cfg_reset_period,
  input  logic [9:0]           cfg_clk_period,
  input  logic [9:0]           cfg_th0_period,
  input  logic [9:0]           cfg_th1_period,
  input  logic [NUM_PORTS-1:0] port_enb,
  input  logic [NUM_PORTS-1:0] port_rgbw,
  ws281x_mport_if.slave        push,
  output logic [NUM_PORTS-1:0] port_busy,
  output logic [NUM_PORTS-1:0] txd
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BIT   = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  logic [9:0]           per_s;
  logic [15:0]          lp_s;
  logic [NUM_PORTS-1:0] ready_s;

  // Degenerate timing settings are clamped so a bit and a latch always last.
  assign per_s = (cfg_clk_period < 10'd2) ? 10'd2 : cfg_clk_period;
  assign lp_s  = (cfg_reset_period == 16'd0) ? 16'd1 : cfg_reset_period;

  assign push.push_ready = ready_s;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q;
    logic          push_s, pop_s, empty_s;
    logic [31:0]   word_s, load_word_s;
    logic [4:0]    load_idx_s;
    logic [9:0]    th_s;

    state_e        state_q, state_d;
    logic [9:0]    bcnt_q, bcnt_d;
    logic [4:0]    bidx_q, bidx_d;
    logic [31:0]   sh_q, sh_d;
    logic [15:0]   lcnt_q, lcnt_d;
    logic          txd_q, txd_d;

    assign push_s  = push.push_valid[p] & ready_q;
    assign empty_s = (cnt_q == '0);
    assign word_s  = mem_q[rd_q];

    // 24-bit words are left-aligned so sh_q[31] is always the current bit.
    assign load_word_s = port_rgbw[p] ? word_s : {word_s[23:0], 8'h00};
    assign load_idx_s  = port_rgbw[p] ? 5'd31 : 5'd23;
    assign th_s        = sh_q[31] ? cfg_th1_period : cfg_th0_period;

    always_comb begin
      cnt_d = cnt_q;
      if (push_s && !pop_s) begin
        cnt_d = cnt_q + (AW+1)'(1);
      end else if (!push_s && pop_s) begin
        cnt_d = cnt_q - (AW+1)'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    always_ff @(posedge mclk) begin
      if (push_s) begin
        mem_q[wr_q] <= push.push_data[32*p +: 32];
      end
    end

    // Ready is registered from the next occupancy, so a pop never frees a slot early.
    always_ff @(posedge mclk) begin
      if (h_reset) begin
        wr_q    <= '0;
        rd_q    <= '0;
        cnt_q   <= '0;
        ready_q <= 1'b0;
      end else begin
        if (push_s) wr_q <= wr_q + AW'(1);
        if (pop_s)  rd_q <= rd_q + AW'(1);
        cnt_q   <= cnt_d;
        ready_q <= (cnt_d < (AW+1)'(FIFO_DEPTH));
      end
    end

    always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      bidx_d  = bidx_q;
      sh_d    = sh_q;
      lcnt_d  = lcnt_q;
      pop_s   = 1'b0;
      txd_d   = (state_q == S_BIT) && (bcnt_q < th_s);
      case (state_q)
        S_IDLE: begin
          if (port_enb[p] && !empty_s) begin
            pop_s   = 1'b1;
            sh_d    = load_word_s;
            bidx_d  = load_idx_s;
            bcnt_d  = 10'd0;
            state_d = S_BIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BIT: begin
          if (bcnt_q >= per_s - 10'd1) begin
            bcnt_d = 10'd0;
            if (bidx_q == 5'd0) begin
              if (port_enb[p] && !empty_s) begin
                pop_s  = 1'b1;
                sh_d   = load_word_s;
                bidx_d = load_idx_s;
              end else begin
                lcnt_d  = 16'd0;
                state_d = S_LATCH;
              end
            end else begin
              bidx_d = bidx_q - 5'd1;
              sh_d   = {sh_q[30:0], 1'b0};
            end
          end else begin
            bcnt_d = bcnt_q + 10'd1;
          end
        end
        S_LATCH: begin
          if (lcnt_q >= lp_s - 16'd1) begin
            lcnt_d  = 16'd0;
            state_d = S_IDLE;
          end else begin
            lcnt_d = lcnt_q + 16'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // txd lags the FSM by one cycle, giving the two-edge push-to-output latency.
    always_ff @(posedge mclk) begin
      if (h_reset) begin
        state_q <= S_IDLE;
        bcnt_q  <= 10'd0;
        bidx_q  <= 5'd0;
        sh_q    <= 32'd0;
        lcnt_q  <= 16'd0;
        txd_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        bcnt_q  <= bcnt_d;
        bidx_q  <= bidx_d;
        sh_q    <= sh_d;
        lcnt_q  <= lcnt_d;
        txd_q   <= txd_d;
      end
    end

    assign txd[p]       = txd_q;
    assign port_busy[p] = (state_q != S_IDLE);
    assign ready_s[p]   = ready_q;
  end

endmodule

// File: tb/tb_ws281x_mport.sv
// Directed bench for ws281x_mport: records txd/busy per cycle and compares
// them against a bit-timing model built from the pushed words.
module tb_ws281x_mport;
  localparam int NP   = 4;
  localparam int RECN = 1024;

  logic          mclk = 1'b0;
  logic          h_reset;
  logic [15:0]   cfg_reset_period;
  logic [9:0]    cfg_clk_period, cfg_th0_period, cfg_th1_period;
  logic [NP-1:0] port_enb, port_rgbw, port_busy, txd;

  ws281x_mport_if #(.NUM_PORTS(NP)) bus ();

  ws281x_mport #(.NUM_PORTS(NP), .FIFO_DEPTH(4)) dut (
    .mclk             (mclk),
    .h_reset          (h_reset),
    .cfg_reset_period (cfg_reset_period),
    .cfg_clk_period   (cfg_clk_period),
    .cfg_th0_period   (cfg_th0_period),
    .cfg_th1_period   (cfg_th1_period),
    .port_enb         (port_enb),
    .port_rgbw        (port_rgbw),
    .push             (bus),
    .port_busy        (port_busy),
    .txd              (txd)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;
  logic [NP-1:0] rec_txd  [RECN];
  logic [NP-1:0] rec_busy [RECN];

  typedef struct {
    int          port;
    logic        rgbw;
    logic [31:0] data;
    int          clkp, th0, th1, rstp;
    int          nbits, ones;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] words [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge mclk);
  endtask

  task automatic set_cfg(input int clkp, input int th0, input int th1, input int rstp);
    cfg_clk_period   = 10'(clkp);
    cfg_th0_period   = 10'(th0);
    cfg_th1_period   = 10'(th1);
    cfg_reset_period = 16'(rstp);
  endtask

  // Sample n cycles; index 0 is the sample just after the edge that took the push.
  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      rec_txd[k]  = txd;
      rec_busy[k] = port_busy;
      if (k == 0) bus.push_valid = '0;
    end
  endtask

  // s = record index of the first sample of the first bit.
  task automatic check_stream(input string name, input int p, input logic [31:0] w [4],
                              input int nw, input int nb, input int s, input int clkp,
                              input int th0, input int th1, input int rstp, input int n,
                              input int exp_ones);
    int per, lp, nt, et, eb, ones, hc, th1e;
    logic e_t, e_b, b;
    per  = (clkp < 2) ? 2 : clkp;
    lp   = (rstp == 0) ? 1 : rstp;
    nt   = nw * nb * per;
    th1e = (th1 > per) ? per : th1;
    et = 0; eb = 0; ones = 0;
    for (int k = 0; k < n; k++) begin
      e_t = 1'b0;
      if (k >= s && k < s + nt) begin
        b   = w[((k - s) / per) / nb][nb - 1 - (((k - s) / per) % nb)];
        e_t = (((k - s) % per) < (b ? th1 : th0));
      end
      e_b = (k >= s - 1) && (k <= s + nt + lp - 2);
      if (rec_txd[k][p] !== e_t) et++;
      if (rec_busy[k][p] !== e_b) eb++;
    end
    for (int j = 0; j < nw * nb; j++) begin
      hc = 0;
      for (int ph = 0; ph < per; ph++) if (rec_txd[s + j * per + ph][p] === 1'b1) hc++;
      if (hc == th1e) ones++;
    end
    check({name, "/txd_errs"}, et, 0);
    check({name, "/busy_errs"}, eb, 0);
    check({name, "/ones"}, ones, exp_ones);
  endtask

  initial begin
    int n, p;
    vecs[0] = '{port: 0, rgbw: 1'b0, data: 32'h7FA50000, clkp: 10, th0: 3, th1: 7, rstp: 50, nbits: 24, ones: 4};
    vecs[1] = '{port: 0, rgbw: 1'b1, data: 32'h000000FF, clkp: 10, th0: 3, th1: 7, rstp: 50, nbits: 32, ones: 8};
    vecs[2] = '{port: 2, rgbw: 1'b0, data: 32'h00FFFFFF, clkp: 1,  th0: 0, th1: 5, rstp: 0,  nbits: 24, ones: 24};
    vecs[3] = '{port: 3, rgbw: 1'b1, data: 32'h80000001, clkp: 4,  th0: 0, th1: 2, rstp: 3,  nbits: 32, ones: 2};

    h_reset = 1'b1;
    set_cfg(10, 3, 7, 50);
    port_enb  = '1;
    port_rgbw = '0;
    bus.push_valid = '0;
    bus.push_data  = '0;
    repeat (3) tick();
    check("reset/txd", 32'(txd), 32'h0);
    check("reset/busy", 32'(port_busy), 32'h0);
    check("reset/ready", 32'(bus.push_ready), 32'h0);
    h_reset = 1'b0;
    tick();
    check("reset/ready_after", 32'(bus.push_ready), 32'hF);

    // Single-word vectors on various ports, modes and clamped timings.
    for (int i = 0; i < 4; i++) begin
      p = vecs[i].port;
      set_cfg(vecs[i].clkp, vecs[i].th0, vecs[i].th1, vecs[i].rstp);
      port_rgbw[p] = vecs[i].rgbw;
      tick();
      words[0] = vecs[i].data;
      bus.push_data[32*p +: 32] = vecs[i].data;
      bus.push_valid[p] = 1'b1;
      n = 2 + vecs[i].nbits * ((vecs[i].clkp < 2) ? 2 : vecs[i].clkp) + vecs[i].rstp + 5;
      record(n);
      check_stream($sformatf("vec%0d", i), p, words, 1, vecs[i].nbits, 2, vecs[i].clkp,
                   vecs[i].th0, vecs[i].th1, vecs[i].rstp, n, vecs[i].ones);
    end

    // Fill a disabled port, overflow once, then drain four words back-to-back.
    set_cfg(4, 1, 3, 5);
    port_rgbw = '0;
    port_enb  = 4'b1101;
    words = '{32'h00123456, 32'h00FFFFFF, 32'h00000000, 32'h00C3C3C3};
    for (int i = 0; i < 4; i++) begin
      bus.push_data[63:32] = words[i];
      bus.push_valid[1] = 1'b1;
      tick();
      check($sformatf("fill/ready%0d", i), 32'(bus.push_ready[1]), (i < 3) ? 32'h1 : 32'h0);
    end
    bus.push_data[63:32] = 32'h00AAAAAA;
    tick();
    check("fill/ready_full", 32'(bus.push_ready[1]), 32'h0);
    bus.push_valid = '0;
    port_enb = 4'hF;
    n = 1 + 96 * 4 + 5 + 6;
    record(n);
    check_stream("fill", 1, words, 4, 24, 1, 4, 1, 3, 5, n, 45);
    check("fill/ready_end", 32'(bus.push_ready), 32'hF);

    // Two ports pushed together with different modes and data.
    set_cfg(5, 1, 4, 7);
    port_rgbw = 4'b0001;
    tick();
    bus.push_data[31:0]  = 32'hDEADBEEF;
    bus.push_data[63:32] = 32'h00C0FFEE;
    bus.push_valid = 4'b0011;
    n = 2 + 32 * 5 + 7 + 5;
    record(n);
    words[0] = 32'hDEADBEEF;
    check_stream("dual_p0", 0, words, 1, 32, 2, 5, 1, 4, 7, n, 24);
    words[0] = 32'h00C0FFEE;
    check_stream("dual_p1", 1, words, 1, 24, 2, 5, 1, 4, 7, n, 16);

    // Reset in the middle of a word with two more words queued.
    set_cfg(10, 3, 7, 50);
    port_rgbw = '0;
    tick();
    bus.push_valid[0] = 1'b1;
    bus.push_data[31:0] = 32'h00FFFFFF;
    tick();
    bus.push_data[31:0] = 32'h00F0F0F0;
    tick();
    bus.push_data[31:0] = 32'h000F0F0F;
    tick();
    bus.push_valid = '0;
    repeat (100) tick();
    check("rst_mid/busy_before", 32'(port_busy[0]), 32'h1);
    h_reset = 1'b1;
    tick();
    check("rst_mid/txd", 32'(txd), 32'h0);
    check("rst_mid/busy", 32'(port_busy), 32'h0);
    check("rst_mid/ready", 32'(bus.push_ready), 32'h0);
    h_reset = 1'b0;
    tick();
    check("rst_mid/ready_after", 32'(bus.push_ready), 32'hF);
    repeat (5) tick();
    check("rst_mid/fifo_empty", 32'(port_busy), 32'h0);
    bus.push_data[31:0] = 32'h00A50000;
    bus.push_valid[0] = 1'b1;
    words[0] = 32'h00A50000;
    n = 2 + 24 * 10 + 50 + 5;
    record(n);
    check_stream("rst_mid/after", 0, words, 1, 24, 2, 10, 3, 7, 50, n, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws281x_mport.md
WS281X_MPORT -- requirements
Module: ws281x_mport

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of independent serial LED outputs (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, words buffered per port (power of 2, 2..16).
REQ-003 SHALL have port mclk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port h_reset  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port cfg_reset_period  input  16  latch (reset) low time in mclk cycles.
REQ-006 SHALL have port cfg_clk_period  input  10  total bit period in mclk cycles.
REQ-007 SHALL have port cfg_th0_period  input  10  high time of a 0-bit in mclk cycles.
REQ-008 SHALL have port cfg_th1_period  input  10  high time of a 1-bit in mclk cycles.
REQ-009 SHALL have port port_enb  input  NUM_PORTS  per-port transmit enable.
REQ-010 SHALL have port port_rgbw  input  NUM_PORTS  per-port word mode: 0 = 24-bit GRB, 1 = 32-bit GRBW.
REQ-011 SHALL have port push_valid  input  NUM_PORTS  per-port write strobe.
REQ-012 SHALL have port push_data  input  32*NUM_PORTS  per-port pixel word; port p at [32p+31:32p].
REQ-013 SHALL have port push_ready  output  NUM_PORTS  per-port FIFO not full.
REQ-014 SHALL have port port_busy  output  NUM_PORTS  port not in IDLE.
REQ-015 SHALL have port txd  output  NUM_PORTS  registered serial data to LED chain.

Function
REQ-016 SHALL accept a word into port p's FIFO at an edge where push_valid[p] and push_ready[p] are both high; push while full is dropped.
REQ-017 SHALL drive push_ready[p] high iff FIFO p holds fewer than FIFO_DEPTH words; a pop and a push in the same cycle when full SHALL NOT accept the push.
REQ-018 SHALL run one FSM per port, states IDLE, BIT, LATCH.
REQ-019 IDLE: txd low; if port_enb[p] and FIFO non-empty, pop one word, load shift register, sample port_rgbw[p] into the word length, go to BIT.
REQ-020 Word length: 24 bits from data[23:0] when rgbw=0, 32 bits from data[31:0] when rgbw=1; MSB first in both modes.
REQ-021 BIT: cycle counter runs 0..cfg_clk_period-1; txd high while counter < th (th1 for a 1-bit, th0 for a 0-bit), low otherwise.
REQ-022 Bit period SHALL be exactly cfg_clk_period cycles; values below 2 SHALL be treated as 2.
REQ-023 th >= cfg_clk_period SHALL give txd high for the whole bit; th = 0 SHALL give txd low for the whole bit.
REQ-024 After the last bit of a word: if port_enb[p] and FIFO non-empty, pop and start the next word's first bit on the next cycle with no gap; otherwise go to LATCH.
REQ-025 LATCH: txd low for exactly cfg_reset_period cycles (0 treated as 1), then IDLE; words arriving during LATCH wait.
REQ-026 port_enb[p] deasserted mid-word SHALL complete the current word, then enter LATCH; FIFO contents are retained.
REQ-027 Latency: word pushed at edge E into an empty FIFO of an idle enabled port SHALL raise txd at edge E+2.
REQ-028 cfg_* SHALL be used live; software changes them only while all ports are idle; a mid-word change SHALL never alter bit count.
REQ-029 Ports SHALL be fully independent; simultaneous pushes and pops on different ports SHALL not interact.
REQ-030 port_busy[p] SHALL be high in BIT and LATCH.

Reset
REQ-031 While h_reset is high at an edge: all FSMs IDLE, all FIFOs empty, counters cleared, txd = 0, port_busy = 0, push_ready = 0.
REQ-032 The first edge after h_reset falls SHALL see push_ready = all ones; reset asserted mid-word SHALL abort the word with txd low on the next edge.

Verification
REQ-033 clk=10, th0=3, th1=7, reset=50, rgbw=0, push 0xA50000 on port 0 -> 24 bits, txd high 7,3,7,3,3,7,3,7 then 3 x16; then 50 low cycles; busy falls.
REQ-034 rgbw=1, push 0x000000FF -> 32 bit periods, last 8 high for 7 cycles; total 320 cycles before LATCH.
REQ-035 FIFO_DEPTH=4, port disabled, 5 pushes -> push_ready low after 4th, 5th dropped; enable -> 4 words back-to-back, 96 bit periods with no gap, then LATCH.
REQ-036 Ports 0 and 1 pushed the same cycle with different data and modes -> independent, cycle-exact waveforms matching single-port runs.
REQ-037 h_reset pulsed at bit 10 of a word with 2 words queued -> txd low next edge, FIFO empty, busy 0; new push transmits normally.
